// File: rtl/turbo_tile_interconnect.sv
// Tile bus crossbar: arbitrates N_M Wishbone masters onto one shared bus and decodes local slaves/router.
// Latency: 1 cycle to grant; 0-wait stb/ack pass-through while owned; decode error answered 1 cycle later.
// Backpressure: ungranted masters stall with ack/err low; the owner is stalled by its target's ack/err.
module turbo_tile_interconnect #(
    parameter int               N_M       = 2,
    parameter int               N_S       = 5,
    parameter int               DW        = 128,
    parameter logic [15:0]      TILE_BASE = 16'h0000,
    parameter logic [4*N_S-1:0] SLAVE_IDS = {N_S{4'h0}},
    parameter bit               ARB_RR    = 1'b1,
    parameter int               TIMEOUT   = 255,
    localparam int              SW        = DW / 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_M-1:0]      i_m_cyc,
    input  logic [N_M-1:0]      i_m_stb,
    input  logic [N_M-1:0]      i_m_we,
    input  logic [32*N_M-1:0]   i_m_adr,
    input  logic [SW*N_M-1:0]   i_m_sel,
    input  logic [DW*N_M-1:0]   i_m_dat,
    output logic [DW-1:0]       o_m_dat,
    output logic [N_M-1:0]      o_m_ack,
    output logic [N_M-1:0]      o_m_err,
    output logic [31:0]         o_b_adr,
    output logic [SW-1:0]       o_b_sel,
    output logic                o_b_we,
    output logic [DW-1:0]       o_b_dat,
    output logic                o_b_cyc,
    output logic [N_S-1:0]      o_s_stb,
    input  logic [DW*N_S-1:0]   i_s_dat,
    input  logic [N_S-1:0]      i_s_ack,
    input  logic [N_S-1:0]      i_s_err,
    output logic                o_r_stb,
    input  logic [DW-1:0]       i_r_dat,
    input  logic                i_r_ack,
    input  logic                i_r_err,
    output logic [2:0]          o_grant,
    output logic                o_grant_vld
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    localparam bit         TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_ERR, ST_DECERR} state_t;

    typedef struct packed {
        logic [31:0]   adr;
        logic [SW-1:0] sel;
        logic          we;
        logic [DW-1:0] dat;
        logic          cyc;
        logic          stb;
    } bus_t;

    state_t      state, state_nxt;
    logic [2:0]  grant, grant_nxt;
    logic        grant_vld, grant_vld_nxt;
    logic [2:0]  rr_ptr, rr_ptr_nxt;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;

    bus_t            bus;
    logic            any_req;
    logic [2:0]      win;
    logic            stb_act;
    logic            local_space;
    logic [N_S-1:0]  s_hit;
    logic [N_S-1:0]  s_sel;
    logic            r_sel;
    logic            dec_err;
    logic            tgt_ack;
    logic            tgt_err;
    logic [DW-1:0]   tgt_dat;
    logic            tgt_busy;
    logic            tmo_hit;
    logic            err_state;

    // Granted master's signals onto the shared bus; all zero while unowned.
    always_comb begin
        bus = '0;
        if (grant_vld) begin
            for (int j = 0; j < N_M; j++) begin
                if (grant == 3'(j)) begin
                    bus.adr = i_m_adr[32*j +: 32];
                    bus.sel = i_m_sel[SW*j +: SW];
                    bus.we  = i_m_we[j];
                    bus.dat = i_m_dat[DW*j +: DW];
                    bus.cyc = i_m_cyc[j];
                    bus.stb = i_m_stb[j];
                end
            end
        end
    end

    // Winner = requester with smallest priority distance (RR: distance past rr_ptr).
    always_comb begin
        int best_d;
        int d;
        win     = '0;
        best_d  = N_M;
        d       = 0;
        any_req = |i_m_cyc;
        for (int j = 0; j < N_M; j++) begin
            if (ARB_RR) d = (j + N_M - 1 - int'(rr_ptr)) % N_M;
            else        d = j;
            if (i_m_cyc[j] && d < best_d) begin
                best_d = d;
                win    = 3'(j);
            end
        end
    end

    // Address decode; the descending scan leaves the lowest matching slave on duplicate ids.
    always_comb begin
        s_hit       = '0;
        local_space = (bus.adr[31:16] == TILE_BASE);
        for (int k = N_S - 1; k >= 0; k--) begin
            if (bus.adr[15:12] == SLAVE_IDS[4*k +: 4]) begin
                s_hit    = '0;
                s_hit[k] = 1'b1;
            end
        end
        stb_act = grant_vld && bus.stb && (state == ST_OWN);
        s_sel   = (stb_act && local_space) ? s_hit : '0;
        r_sel   = stb_act && !local_space;
        dec_err = stb_act && local_space && (s_hit == '0);
    end

    always_comb begin
        tgt_ack = 1'b0;
        tgt_err = 1'b0;
        tgt_dat = '0;
        for (int k = 0; k < N_S; k++) begin
            if (s_sel[k]) begin
                tgt_ack = i_s_ack[k];
                tgt_err = i_s_err[k];
                tgt_dat = i_s_dat[DW*k +: DW];
            end
        end
        if (r_sel) begin
            tgt_ack = i_r_ack;
            tgt_err = i_r_err;
            tgt_dat = i_r_dat;
        end
        tgt_busy = ((|s_sel) || r_sel) && !(tgt_ack || tgt_err);
        // A late ack on the limit cycle clears tgt_busy, so the real answer wins over the timeout.
        tmo_hit  = TMO_EN && tgt_busy && (tmo_cnt == TMO_LIMIT);
    end

    assign err_state = (state == ST_ERR) || (state == ST_DECERR);

    always_comb begin
        o_m_ack = '0;
        o_m_err = '0;
        if (grant_vld) begin
            for (int j = 0; j < N_M; j++) begin
                if (grant == 3'(j)) begin
                    o_m_ack[j] = tgt_ack && !tgt_err;
                    o_m_err[j] = tgt_err || err_state;
                end
            end
        end
    end

    assign o_m_dat     = tgt_dat;
    assign o_s_stb     = s_sel;
    assign o_r_stb     = r_sel;
    assign o_b_adr     = bus.adr;
    assign o_b_sel     = bus.sel;
    assign o_b_we      = bus.we;
    assign o_b_dat     = bus.dat;
    assign o_b_cyc     = bus.cyc;
    assign o_grant     = grant;
    assign o_grant_vld = grant_vld;

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_vld_nxt = grant_vld;
        rr_ptr_nxt    = rr_ptr;
        tmo_cnt_nxt   = (tgt_busy && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt     = ST_OWN;
                    grant_nxt     = win;
                    grant_vld_nxt = 1'b1;
                    if (ARB_RR) rr_ptr_nxt = win;
                end
            end
            ST_OWN: begin
                if (!bus.cyc) begin
                    state_nxt     = ST_IDLE;
                    grant_vld_nxt = 1'b0;
                end else if (dec_err) begin
                    state_nxt = ST_DECERR;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR, ST_DECERR: begin
                // The error pulse is already on the outputs; only the return state depends on cyc.
                if (!bus.cyc) begin
                    state_nxt     = ST_IDLE;
                    grant_vld_nxt = 1'b0;
                end else begin
                    state_nxt = ST_OWN;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                grant_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            grant     <= 3'd0;
            grant_vld <= 1'b0;
            rr_ptr    <= 3'(N_M - 1);
            tmo_cnt   <= 8'd0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_vld <= grant_vld_nxt;
            rr_ptr    <= rr_ptr_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_turbo_tile_interconnect.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share master stimulus; a monitor
// pops expected grants/responses whenever an instance raises grant_vld or a master ack/err.
module tb_turbo_tile_interconnect;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam logic [31:0] S0D = 32'h5A00_0000;
    localparam logic [31:0] S2D = 32'h5A00_0002;
    localparam logic [31:0] RD  = 32'hB0B0_0001;

    typedef struct {
        int          m;
        bit          is_err;
        logic [31:0] dat;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   m_cyc = '0, m_stb = '0, m_we = '0;
    logic [63:0]  m_adr = '0;
    logic [7:0]   m_sel = 8'hF3;
    logic [63:0]  m_dat = 64'h2222_2222_1111_1111;
    logic [4:0]   s_ack_en = '1, s_err_en = '0;
    logic         r_ack_en = 1'b1;
    logic [159:0] s_dat = {32'h5A00_0004, 32'h5A00_0003, 32'h5A00_0002, 32'h5A00_0001, 32'h5A00_0000};

    logic [31:0] rr_m_dat, fx_m_dat, rr_b_adr, fx_b_adr, rr_b_dat, fx_b_dat;
    logic [1:0]  rr_m_ack, fx_m_ack, rr_m_err, fx_m_err;
    logic [SW-1:0] rr_b_sel, fx_b_sel;
    logic        rr_b_we, fx_b_we, rr_b_cyc, fx_b_cyc, rr_r_stb, fx_r_stb;
    logic [4:0]  rr_s_stb, fx_s_stb;
    logic [2:0]  rr_grant, fx_grant;
    logic        rr_grant_vld, fx_grant_vld;

    int tests = 0, fails = 0;
    bit rr_mon_en = 1'b1, fx_mon_en = 1'b0;
    resp_t rq_rr[$], rq_fx[$];
    int    gq_rr[$], gq_fx[$];
    int    m0_done = 0;

    always #5 clk = ~clk;

    turbo_tile_interconnect #(.N_M(2), .N_S(5), .DW(DW), .TILE_BASE(16'h0000), .SLAVE_IDS(20'h54321),
                              .ARB_RR(1'b1), .TIMEOUT(8)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_adr(m_adr), .i_m_sel(m_sel), .i_m_dat(m_dat), .o_m_dat(rr_m_dat), .o_m_ack(rr_m_ack),
        .o_m_err(rr_m_err), .o_b_adr(rr_b_adr), .o_b_sel(rr_b_sel), .o_b_we(rr_b_we), .o_b_dat(rr_b_dat),
        .o_b_cyc(rr_b_cyc), .o_s_stb(rr_s_stb), .i_s_dat(s_dat), .i_s_ack(rr_s_stb & s_ack_en),
        .i_s_err(rr_s_stb & s_err_en), .o_r_stb(rr_r_stb), .i_r_dat(RD), .i_r_ack(rr_r_stb & r_ack_en),
        .i_r_err(1'b0), .o_grant(rr_grant), .o_grant_vld(rr_grant_vld));

    turbo_tile_interconnect #(.N_M(2), .N_S(5), .DW(DW), .TILE_BASE(16'h0000), .SLAVE_IDS(20'h54321),
                              .ARB_RR(1'b0), .TIMEOUT(8)) dut_fx (
        .i_clk(clk), .i_rst_n(rst_n), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_adr(m_adr), .i_m_sel(m_sel), .i_m_dat(m_dat), .o_m_dat(fx_m_dat), .o_m_ack(fx_m_ack),
        .o_m_err(fx_m_err), .o_b_adr(fx_b_adr), .o_b_sel(fx_b_sel), .o_b_we(fx_b_we), .o_b_dat(fx_b_dat),
        .o_b_cyc(fx_b_cyc), .o_s_stb(fx_s_stb), .i_s_dat(s_dat), .i_s_ack(fx_s_stb & s_ack_en),
        .i_s_err(fx_s_stb & s_err_en), .o_r_stb(fx_r_stb), .i_r_dat(RD), .i_r_ack(fx_r_stb & r_ack_en),
        .i_r_err(1'b0), .o_grant(fx_grant), .o_grant_vld(fx_grant_vld));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic exp_rsp(input bit fx, input int m, input bit e, input logic [31:0] d);
        resp_t r;
        r.m = m; r.is_err = e; r.dat = d;
        if (fx) rq_fx.push_back(r);
        else    rq_rr.push_back(r);
    endtask

    task automatic chk_resp(input bit fx, input logic [1:0] ack, input logic [1:0] err,
                            input logic [31:0] dat, input logic [2:0] g);
        for (int j = 0; j < 2; j++) begin
            if (ack[j] || err[j]) begin
                resp_t e;
                bit found;
                found = 1'b0;
                tests++;
                if (fx) begin
                    for (int i = 0; i < rq_fx.size(); i++)
                        if (!found && rq_fx[i].m == j) begin e = rq_fx[i]; rq_fx.delete(i); found = 1'b1; end
                end else begin
                    for (int i = 0; i < rq_rr.size(); i++)
                        if (!found && rq_rr[i].m == j) begin e = rq_rr[i]; rq_rr.delete(i); found = 1'b1; end
                end
                if (!found) begin
                    fails++;
                    $display("FAIL resp_unexpected dut%0d m%0d: got ack=%0b err=%0b, expected none", fx, j, ack[j], err[j]);
                end else if (err[j] != e.is_err || (ack[j] && err[j]) || (!e.is_err && dat != e.dat) || g != 3'(j)) begin
                    fails++;
                    $display("FAIL resp dut%0d m%0d: got ack=%0b err=%0b dat=%h grant=%0d, expected err=%0b dat=%h grant=%0d",
                             fx, j, ack[j], err[j], dat, g, e.is_err, e.dat, j);
                end
            end
        end
    endtask

    task automatic chk_grant(input bit fx, input logic [2:0] g);
        int e;
        tests++;
        if (fx ? gq_fx.size() == 0 : gq_rr.size() == 0) begin
            fails++;
            $display("FAIL grant_unexpected dut%0d: got %0d, expected none", fx, g);
        end else begin
            e = fx ? gq_fx.pop_front() : gq_rr.pop_front();
            if (g != 3'(e)) begin
                fails++;
                $display("FAIL grant dut%0d: got %0d, expected %0d", fx, g, e);
            end
        end
    endtask

    task automatic monitor();
        logic rr_vq, fx_vq;
        rr_vq = 1'b0; fx_vq = 1'b0;
        forever begin
            @(negedge clk);
            if (rr_mon_en) begin
                chk_resp(1'b0, rr_m_ack, rr_m_err, rr_m_dat, rr_grant);
                if (rr_grant_vld && !rr_vq) chk_grant(1'b0, rr_grant);
            end
            if (fx_mon_en) begin
                chk_resp(1'b1, fx_m_ack, fx_m_err, fx_m_dat, fx_grant);
                if (fx_grant_vld && !fx_vq) chk_grant(1'b1, fx_grant);
            end
            rr_vq = rr_grant_vld;
            fx_vq = fx_grant_vld;
        end
    endtask

    // One Wishbone single transfer; n = negedges from stb raise to the ack/err sample.
    task automatic xfer(input int j, input logic [31:0] adr, input bit hold, input bit fx,
                        output int n, output logic [4:0] s_at, output logic r_at, output logic post);
        bit got;
        got = 1'b0; n = 0; s_at = '0; r_at = 1'b0;
        @(posedge clk); #1;
        m_cyc[j] = 1'b1; m_stb[j] = 1'b1; m_adr[32*j +: 32] = adr;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got  = fx ? (fx_m_ack[j] | fx_m_err[j]) : (rr_m_ack[j] | rr_m_err[j]);
            s_at = fx ? fx_s_stb : rr_s_stb;
            r_at = fx ? fx_r_stb : rr_r_stb;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL xfer_wait m%0d adr %h: got no ack/err in 100 cycles, expected a response", j, adr);
        end
        @(posedge clk); #1;
        m_stb[j] = 1'b0;
        if (!hold) m_cyc[j] = 1'b0;
        @(negedge clk);
        post = fx ? (fx_m_ack[j] | fx_m_err[j]) : (rr_m_ack[j] | rr_m_err[j]);
    endtask

    initial begin
        int n;
        logic [4:0] s_at;
        logic r_at, post;
        fork monitor(); join_none

        // Reset with both masters requesting: everything quiet.
        m_cyc = 2'b11; m_stb = 2'b11; m_adr = {32'h0000_1000, 32'h0000_1000};
        repeat (3) @(negedge clk);
        chk("rst_s_stb", rr_s_stb, 0);    chk("rst_r_stb", rr_r_stb, 0);
        chk("rst_ack", rr_m_ack, 0);      chk("rst_err", rr_m_err, 0);
        chk("rst_vld", rr_grant_vld, 0);  chk("rst_grant", rr_grant, 0);
        chk("rst_b_cyc", rr_b_cyc, 0);    chk("rst_b_adr", rr_b_adr, 0);
        chk("rst_b_sel", rr_b_sel, 0);    chk("rst_b_dat", rr_b_dat, 0);
        chk("rst_b_we", rr_b_we, 0);      chk("rst_fx_vld", fx_grant_vld, 0);
        @(posedge clk); #1;
        m_cyc = '0; m_stb = '0; m_adr = '0;
        rst_n = 1'b1;

        // Decode: slave 2 (id 3), router, unmapped tile id.
        gq_rr.push_back(0); exp_rsp(0, 0, 0, S2D);
        xfer(0, 32'h0000_3010, 0, 0, n, s_at, r_at, post);
        chk("dec_s2_stb", s_at, 5'b00100); chk("dec_s2_lat", n, 2);
        gq_rr.push_back(0); exp_rsp(0, 0, 0, RD);
        xfer(0, 32'h8000_0000, 0, 0, n, s_at, r_at, post);
        chk("dec_rtr_stb", r_at, 1); chk("dec_rtr_sstb", s_at, 0);
        gq_rr.push_back(0); exp_rsp(0, 0, 1, 0);
        xfer(0, 32'h0000_F000, 0, 0, n, s_at, r_at, post);
        chk("decerr_lat", n, 3); chk("decerr_stb", {s_at, r_at}, 0); chk("decerr_1cyc", post, 0);

        // Slave 3 answers ack and err together: err only.
        s_err_en = 5'b01000;
        gq_rr.push_back(0); exp_rsp(0, 0, 1, 0);
        xfer(0, 32'h0000_4000, 0, 0, n, s_at, r_at, post);
        chk("ackerr_lat", n, 2);
        s_err_en = '0;

        // Timeout 8: err 9 cycles after stb reaches the slave, single pulse, strobe withdrawn.
        s_ack_en = 5'b11110;
        gq_rr.push_back(0); exp_rsp(0, 0, 1, 0);
        xfer(0, 32'h0000_1000, 0, 0, n, s_at, r_at, post);
        chk("tmo_lat", n, 11); chk("tmo_stb", s_at, 0); chk("tmo_1cyc", post, 0);
        s_ack_en = '1;

        // Round-robin contention, pointer now at 0: grants 1,0,1,0,...
        for (int i = 0; i < 4; i++) begin
            gq_rr.push_back(1); gq_rr.push_back(0);
            exp_rsp(0, 0, 0, S0D); exp_rsp(0, 1, 0, RD);
        end
        fork
            begin
                int n0; logic [4:0] s0; logic r0, p0;
                for (int i = 0; i < 4; i++) xfer(0, 32'h0000_1000, 0, 0, n0, s0, r0, p0);
            end
            begin
                int n1; logic [4:0] s1; logic r1, p1;
                for (int i = 0; i < 4; i++) xfer(1, 32'h8000_0000, 0, 0, n1, s1, r1, p1);
            end
        join
        @(negedge clk);
        chk("rr_rsp_left", rq_rr.size(), 0); chk("rr_gnt_left", gq_rr.size(), 0);

        // Fixed priority: m1 waits for every m0 transfer, even across a re-request.
        rr_mon_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        fx_mon_en = 1'b1;
        gq_fx.push_back(0); gq_fx.push_back(0); gq_fx.push_back(1);
        for (int i = 0; i < 4; i++) exp_rsp(1, 0, 0, S0D);
        exp_rsp(1, 1, 0, RD);
        fork
            begin
                int n0; logic [4:0] s0; logic r0, p0;
                xfer(0, 32'h0000_1000, 1, 1, n0, s0, r0, p0); m0_done++;
                xfer(0, 32'h0000_1000, 1, 1, n0, s0, r0, p0); m0_done++;
                xfer(0, 32'h0000_1000, 0, 1, n0, s0, r0, p0); m0_done++;
                xfer(0, 32'h0000_1000, 0, 1, n0, s0, r0, p0); m0_done++;
            end
            begin
                int n1; logic [4:0] s1; logic r1, p1;
                xfer(1, 32'h8000_0000, 0, 1, n1, s1, r1, p1);
                chk("fx_m1_after_m0", m0_done, 4);
            end
        join

        // Reset while m1 owns the bus: outputs drop at once, then lowest requester wins.
        gq_fx.push_back(1); gq_fx.push_back(0);
        @(posedge clk); #1;
        r_ack_en = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[63:32] = 32'h8000_0000;
        repeat (2) @(negedge clk);
        chk("mid_own_rstb", fx_r_stb, 1); chk("mid_own_grant", fx_grant, 1);
        m_cyc[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", fx_grant_vld, 0); chk("mid_rst_rstb", fx_r_stb, 0);
        chk("mid_rst_cyc", fx_b_cyc, 0);     chk("mid_rst_adr", fx_b_adr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("resume_grant", {fx_grant_vld, fx_grant}, {1'b1, 3'd0});
        chk("resume_adr", fx_b_adr, 32'h0000_1000);
        chk("resume_sel", fx_b_sel, 4'h3);
        chk("resume_dat", fx_b_dat, 32'h1111_1111);
        chk("resume_we", fx_b_we, 0);
        @(posedge clk); #1;
        m_cyc = '0; m_stb = '0; r_ack_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("fx_rsp_left", rq_fx.size(), 0); chk("fx_gnt_left", gq_fx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
